// File: rtl/nanorv32_csr.sv
// nanorv32_csr_exec: runs CSRRW/RS/RC(I) as a read-modify-write
// sequence on the CSR bus and stalls execute until the old value is ready.
module nanorv32_csr_exec #(
  parameter int CSR_ADDR_W = 12,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exe_csr_valid,
  input  logic [1:0]            exe_csr_op,
  input  logic                  exe_csr_imm_sel,
  input  logic [CSR_ADDR_W-1:0] exe_csr_addr,
  input  logic [DATA_W-1:0]     exe_csr_rs1_data,
  input  logic                  exe_csr_rs1_is_x0,
  input  logic [4:0]            exe_csr_zimm,
  input  logic                  stall_exe,
  output logic                  csr_exe_stall,
  output logic [DATA_W-1:0]     csr_exe_rd_wdata,
  output logic                  csr_exe_rd_we,
  output logic                  csr_exe_illegal,
  output logic [CSR_ADDR_W-1:0] core_csr_addr,
  output logic [DATA_W-1:0]     core_csr_wdata,
  output logic                  core_csr_write,
  input  logic [DATA_W-1:0]     csr_core_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [CSR_ADDR_W-1:0] addr_r;
  logic [1:0]            op_r;
  logic [DATA_W-1:0]     src_r;
  logic [DATA_W-1:0]     rdata_r;
  logic [DATA_W-1:0]     wdata_r;
  logic                  wr_req_r;
  logic                  illegal_r;

  logic [DATA_W-1:0] src;
  logic              src_nz;
  logic              wr_req;
  logic              illegal;
  logic              accept;
  logic [DATA_W-1:0] mod_val;
  logic              done_go;

  always_comb begin
    src = exe_csr_rs1_data;
    src_nz = !exe_csr_rs1_is_x0;
    if (exe_csr_imm_sel) begin
      src = {{(DATA_W-5){1'b0}}, exe_csr_zimm};
      src_nz = |exe_csr_zimm;
    end
  end

  // The top two address bits equal to 11 mark a read-only CSR.
  assign wr_req  = (exe_csr_op == 2'b01) | src_nz;
  assign illegal = (exe_csr_op == 2'b00) |
                   ((exe_csr_addr[CSR_ADDR_W-1 -: 2] == 2'b11)
                    & wr_req);
  assign accept  = exe_csr_valid & !stall_exe;

  always_comb begin
    case (op_r)
      2'b01:   mod_val = src_r;
      2'b10:   mod_val = csr_core_rdata | src_r;
      2'b11:   mod_val = csr_core_rdata & ~src_r;
      default: mod_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_r    <= '0;
      op_r      <= '0;
      src_r     <= '0;
      rdata_r   <= '0;
      wdata_r   <= '0;
      wr_req_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_r    <= exe_csr_addr;
            op_r      <= exe_csr_op;
            src_r     <= src;
            wr_req_r  <= wr_req;
            illegal_r <= illegal;
            rdata_r   <= '0;
            state     <= illegal ? DONE : READ;
          end
        end
        READ: begin
          rdata_r <= csr_core_rdata;
          wdata_r <= mod_val;
          state   <= wr_req_r ? WRITE : DONE;
        end
        WRITE: state <= DONE;
        DONE: begin
          if (!stall_exe)
            state <= IDLE;
        end
      endcase
    end
  end

  // Every output is gated by rst_n so a reset cycle never leaks
  // a write strobe or rd write from the aborted sequence.
  assign csr_exe_stall = rst_n &
                         (((state == IDLE) & exe_csr_valid) |
                          (state == READ) |
                          (state == WRITE));

  assign core_csr_addr =
    (rst_n && state != IDLE) ? addr_r : '0;
  assign core_csr_write = rst_n && (state == WRITE);
  assign core_csr_wdata =
    core_csr_write ? wdata_r : '0;

  assign done_go          = rst_n && (state == DONE) && !stall_exe;
  assign csr_exe_rd_we    = done_go & !illegal_r;
  assign csr_exe_illegal  = done_go & illegal_r;
  assign csr_exe_rd_wdata = csr_exe_rd_we ? rdata_r : '0;

endmodule

// File: tb/tb_nanorv32_csr_exec.sv
// Scoreboard bench for nanorv32_csr_exec: stimulus pushes expected
// bus/rd/illegal events, a negedge monitor pops and compares them.
module tb_nanorv32_csr_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [1:0]  op;
  logic        imm_sel;
  logic [11:0] addr;
  logic [31:0] rs1_data;
  logic        rs1_is_x0;
  logic [4:0]  zimm;
  logic        stall_exe;
  logic        stall;
  logic [31:0] rd_wdata;
  logic        rd_we;
  logic        illegal;
  logic [11:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_write;
  logic [31:0] c_rdata;

  nanorv32_csr_exec dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exe_csr_valid     (valid),
    .exe_csr_op        (op),
    .exe_csr_imm_sel   (imm_sel),
    .exe_csr_addr      (addr),
    .exe_csr_rs1_data  (rs1_data),
    .exe_csr_rs1_is_x0 (rs1_is_x0),
    .exe_csr_zimm      (zimm),
    .stall_exe         (stall_exe),
    .csr_exe_stall     (stall),
    .csr_exe_rd_wdata  (rd_wdata),
    .csr_exe_rd_we     (rd_we),
    .csr_exe_illegal   (illegal),
    .core_csr_addr     (c_addr),
    .core_csr_wdata    (c_wdata),
    .core_csr_write    (c_write),
    .csr_core_rdata    (c_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR block model: 0xC00 is a free-running cycle counter,
  // 0x340 is a writable scratch register.
  logic [31:0] cyc_base = '0;
  logic [31:0] mscratch = '0;
  logic        preset_en = 1'b0;
  logic [31:0] preset_val = '0;

  always @(posedge clk) begin
    if (preset_en)
      mscratch <= preset_val;
    else if (c_write && c_addr == 12'h340)
      mscratch <= c_wdata;
  end

  always_comb begin
    c_rdata = '0;
    if (c_addr == 12'hC00)
      c_rdata = cyc_base + 32'(cyc);
    else if (c_addr == 12'h340)
      c_rdata = mscratch;
  end

  typedef struct {
    int          kind;
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_ILL = 2;

  task automatic push(input int kind, input int c,
                      input logic [11:0] a,
                      input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind,
                     input logic [11:0] a,
                     input logic [31:0] d);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d a=%h d=%h",
               kind, cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          e.addr != a || e.data != d) begin
        fails++;
        $display({"FAIL event got kind=%0d cyc=%0d a=%h d=%h",
                  " want kind=%0d cyc=%0d a=%h d=%h"},
                 kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (c_write) got(EV_WR, c_addr, c_wdata);
    if (rd_we) got(EV_RD, 12'h0, rd_wdata);
    if (illegal) got(EV_ILL, 12'h0, 32'h0);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic preset(input logic [31:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    @(posedge clk); #1;
    preset_en = 1'b0;
  endtask

  // Drive one instruction; len = cycles incl. DONE (stall checked on
  // each), or 1 to return right after the accept edge.
  task automatic issue(input logic [1:0] o, input logic im,
                       input logic [11:0] a,
                       input logic [31:0] r,
                       input logic x0, input logic [4:0] z,
                       input int len);
    valid     = 1'b1;
    op        = o;
    imm_sel   = im;
    addr      = a;
    rs1_data  = r;
    rs1_is_x0 = x0;
    zimm      = z;
    @(negedge clk);
    chk("stall_accept", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      chk("stall_seq", {31'b0, stall},
          (i < len - 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_write"}, {31'b0, c_write}, 32'd0);
    chk({tag, "_rd_we"}, {31'b0, rd_we}, 32'd0);
    chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
    chk({tag, "_addr"}, {20'b0, c_addr}, 32'd0);
    chk({tag, "_wdata"}, c_wdata, 32'd0);
  endtask

  int k;

  initial begin
    rst_n     = 1'b0;
    valid     = 1'b1;
    op        = 2'b01;
    imm_sel   = 1'b0;
    addr      = 12'h340;
    rs1_data  = 32'h1;
    rs1_is_x0 = 1'b0;
    zimm      = 5'd0;
    stall_exe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset_valid");
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("after_reset");
    @(posedge clk); #1;

    // CSRRS x5, cycle, x0: counter reads 100 in READ
    k = cyc;
    cyc_base = 32'd100 - 32'(k + 1);
    push(EV_RD, k + 2, 12'h0, 32'd100);
    issue(2'b10, 1'b0, 12'hC00, 32'h0, 1'b1, 5'd0, 3);

    // CSRRW 0x340 <- 0xDEADBEEF, old 0x12
    preset(32'h12);
    k = cyc;
    push(EV_WR, k + 2, 12'h340, 32'hDEADBEEF);
    push(EV_RD, k + 3, 12'h0, 32'h12);
    issue(2'b01, 1'b0, 12'h340, 32'hDEADBEEF, 1'b0, 5'd0, 4);

    // back-to-back: CSRRCI 0x340, 3 with old 0xF... preceded by
    // a read of the value just written
    k = cyc;
    push(EV_RD, k + 2, 12'h0, 32'hDEADBEEF);
    issue(2'b10, 1'b0, 12'h340, 32'h0, 1'b1, 5'd0, 3);

    preset(32'hF);
    k = cyc;
    push(EV_WR, k + 2, 12'h340, 32'hC);
    push(EV_RD, k + 3, 12'h0, 32'hF);
    issue(2'b11, 1'b1, 12'h340, 32'hFFFF_FFFF, 1'b0, 5'd3, 4);

    // CSRRSI zimm=0: read only, no write
    k = cyc;
    push(EV_RD, k + 2, 12'h0, 32'hC);
    issue(2'b10, 1'b1, 12'h340, 32'hFFFF_FFFF, 1'b0, 5'd0, 3);

    // CSRRS register form, rs1=0x30
    k = cyc;
    push(EV_WR, k + 2, 12'h340, 32'h3C);
    push(EV_RD, k + 3, 12'h0, 32'hC);
    issue(2'b10, 1'b0, 12'h340, 32'h30, 1'b0, 5'd0, 4);

    // CSRRW to read-only cycle CSR
    k = cyc;
    push(EV_ILL, k + 1, 12'h0, 32'h0);
    issue(2'b01, 1'b0, 12'hC00, 32'h5, 1'b0, 5'd0, 2);

    // op=00
    k = cyc;
    push(EV_ILL, k + 1, 12'h0, 32'h0);
    issue(2'b00, 1'b0, 12'h340, 32'h5, 1'b0, 5'd0, 2);

    // CSRRS with nonzero rs1 to a read-only CSR
    k = cyc;
    push(EV_ILL, k + 1, 12'h0, 32'h0);
    issue(2'b10, 1'b0, 12'hC00, 32'h1, 1'b0, 5'd0, 2);

    // stall_exe held through 3 DONE cycles (raised in READ)
    k = cyc;
    push(EV_RD, k + 5, 12'h0, 32'h3C);
    issue(2'b10, 1'b0, 12'h340, 32'h0, 1'b1, 5'd0, 1);
    stall_exe = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    stall_exe = 1'b0;
    @(posedge clk); #1;

    // reset during READ of a CSRRW: aborted, no write
    issue(2'b01, 1'b0, 12'h340, 32'h55, 1'b0, 5'd0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("rst_in_read");
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("rst_next");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    k = cyc;
    push(EV_RD, k + 2, 12'h0, 32'h3C);
    issue(2'b10, 1'b0, 12'h340, 32'h0, 1'b1, 5'd0, 3);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
